// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock through an external add/subtract selector.
// Start is sampled only in IDLE. The 64-bit product is held until the next completed operation.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [1:0]           as_ctrl,
    output logic [WIDTH-1:0]     as_a,
    output logic [WIDTH-1:0]     as_b,
    input  logic [WIDTH-1:0]     as_y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] CTRL_PASS = 2'd0;
    localparam logic [1:0] CTRL_ADD  = 2'd1;
    localparam logic [1:0] CTRL_SUB  = 2'd2;

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              qm1_q, qm1_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              ovf;
    logic              sign_in;

    // Selector drive: Booth recoding of the current multiplier bit pair
    always_comb begin
        as_ctrl = CTRL_PASS;
        if (state_q == ST_RUN) begin
            case ({q_q[0], qm1_q})
                2'b10:   as_ctrl = CTRL_SUB;
                2'b01:   as_ctrl = CTRL_ADD;
                default: as_ctrl = CTRL_PASS;
            endcase
        end
    end

    assign as_a = a_q;
    assign as_b = m_q;

    // True sign of the W+1-bit sum, so M = -2^(W-1) shifts in correctly
    always_comb begin
        ovf = 1'b0;
        case (as_ctrl)
            CTRL_ADD: ovf = (a_q[WIDTH-1] == m_q[WIDTH-1]) && (as_y[WIDTH-1] != a_q[WIDTH-1]);
            CTRL_SUB: ovf = (a_q[WIDTH-1] != m_q[WIDTH-1]) && (as_y[WIDTH-1] != a_q[WIDTH-1]);
            default:  ovf = 1'b0;
        endcase
        sign_in = as_y[WIDTH-1] ^ ovf;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = multiplicand;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Arithmetic shift right of {as_y, Q, q_m1}
                a_d   = {sign_in, as_y[WIDTH-1:1]};
                q_d   = {as_y[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = {sign_in, as_y, q_q[WIDTH-1:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a behavioural add/subtract selector.
// Products are compared against hand-computed constants and 64-bit signed multiplies done in the bench.
module tb_booth_mul_seq;

    localparam int unsigned W = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic [1:0]      as_ctrl;
    logic [W-1:0]    as_a;
    logic [W-1:0]    as_b;
    logic [W-1:0]    as_y;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .as_ctrl      (as_ctrl),
        .as_a         (as_a),
        .as_b         (as_b),
        .as_y         (as_y),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared selector stage model
    always_comb begin
        case (as_ctrl)
            2'd1:    as_y = as_a + as_b;
            2'd2:    as_y = as_a - as_b;
            default: as_y = as_a;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] booth_code(input logic [W-1:0] q, input int i);
        logic lo;
        lo = (i == 0) ? 1'b0 : q[i-1];
        case ({q[i], lo})
            2'b10:   return 2'd2;
            2'b01:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // mode 0: plain pulse; mode 1: extra start with other operands mid-run
    task automatic run_mul(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                           input logic [63:0] exp, input int mode);
        int n;
        int extra_done;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            if (n < 32 && (n % 8 == 0 || mode == 1))
                check({tag, "_as_ctrl"}, 64'(as_ctrl), 64'(booth_code(q, n)));
            if (mode == 1 && n == 10) begin
                multiplicand = 32'd99;
                multiplier   = 32'd77;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 64'(done), 64'd0);
        check({tag, "_idle_ctrl"}, 64'(as_ctrl), 64'd0);
        if (mode == 1) begin
            extra_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            check({tag, "_no_second_done"}, 64'(extra_done), 64'd0);
            check({tag, "_product_kept"}, product, exp);
        end
    endtask

    initial begin
        logic [W-1:0] rm;
        logic [W-1:0] rq;
        logic [63:0]  rexp;
        int n;
        int stray;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset_busy",    64'(busy),    64'd0);
        check("reset_done",    64'(done),    64'd0);
        check("reset_product", product,      64'd0);
        check("reset_as_ctrl", 64'(as_ctrl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul("m3_q5",     32'd3,         32'd5,         64'h0000_0000_0000_000F, 0);
        run_mul("mneg3_q5",  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_mul("mneg1_qneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        run_mul("min_min",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        run_mul("max_max",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0);
        run_mul("min_max",   32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 0);
        run_mul("ignored_start", 32'd1234,  32'hFFFF_FF00, 64'hFFFF_FFFF_FFFB_2E00, 1);

        for (int r = 0; r < 4; r++) begin
            rm   = $urandom;
            rq   = $urandom;
            rexp = 64'($signed(rm)) * 64'($signed(rq));
            run_mul("random", rm, rq, rexp, 1);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_done",    64'(done),    64'd0);
        check("midrst_product", product,      64'd0);
        check("midrst_as_ctrl", 64'(as_ctrl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("midrst_abandoned", 64'(stray), 64'd0);
        run_mul("after_rst_7x6", 32'd7, 32'd6, 64'd42, 0);

        // Start held high: back-to-back operations
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'hFFFF_FFFC;
        start        = 1'b1;
        n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("held_first_product", product, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int p = 0; p < 3; p++) begin
            n = 0;
            @(negedge clk);
            n++;
            while (!done && n < 80) begin
                @(negedge clk);
                n++;
            end
            check("held_period",  64'(n), 64'd33);
            check("held_product", product, 64'hFFFF_FFFF_FFFF_FFF8);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("held_release_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
